// File: rtl/shift_rows.sv
`default_nettype none
// ============================================================================
// Module      : shift_rows
// Description : AES ShiftRows / InvShiftRows byte permutation with optional
//               single-stage valid/ready output register.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_rows #(
    parameter int PIPE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         inv,
    input  logic [127:0] state_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out
);

    // Byte k sits at row k%4, column k/4; row r rotates by r columns.
    function automatic logic [127:0] permute(input logic [127:0] s, input logic inv_sel);
        logic [127:0] res;
        int           src_col;
        res = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                src_col = inv_sel ? ((c + 4 - r) % 4) : ((c + r) % 4);
                res[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*src_col) -: 8];
            end
        end
        return res;
    endfunction

    logic [127:0] w_shifted;
    assign w_shifted = permute(state_in, inv);

    generate
        if (PIPE != 0) begin : g_pipe
            logic         valid_q;
            logic         valid_d;
            logic [127:0] state_q;
            logic [127:0] state_d;
            logic         w_accept;

            assign in_ready = !valid_q || out_ready;
            assign w_accept = in_valid && in_ready;

            always_comb begin
                valid_d = valid_q;
                state_d = state_q;
                if (w_accept) begin
                    valid_d = 1'b1;
                    state_d = w_shifted;
                end else if (valid_q && out_ready) begin
                    valid_d = 1'b0;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_q <= 1'b0;
                    state_q <= '0;
                end else begin
                    valid_q <= valid_d;
                    state_q <= state_d;
                end
            end

            assign out_valid = valid_q;
            assign state_out = state_q;
        end else begin : g_comb
            // Clock and reset have no function in the pass-through build.
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst_n;

            assign in_ready  = out_ready;
            assign out_valid = in_valid;
            assign state_out = w_shifted;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_shift_rows.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_rows
// Description : Self-checking bench for shift_rows (PIPE=1 and PIPE=0 builds).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_rows;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid;
    logic         inv;
    logic [127:0] state_in;
    logic         out_ready;
    logic         in_ready, out_valid;
    logic [127:0] state_out;
    logic         c_in_ready, c_out_valid;
    logic [127:0] c_state_out;

    int checks = 0;
    int errors = 0;
    logic [127:0] exp_q[$];

    always #5 clk = ~clk;

    shift_rows #(.PIPE(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .inv(inv), .state_in(state_in), .out_valid(out_valid),
        .out_ready(out_ready), .state_out(state_out)
    );

    shift_rows #(.PIPE(0)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(c_in_ready),
        .inv(inv), .state_in(state_in), .out_valid(c_out_valid),
        .out_ready(out_ready), .state_out(c_state_out)
    );

    // Reference: out[r][c] = in[r][(c +/- r) mod 4], byte k at row k%4, col k/4.
    function automatic logic [127:0] ref_shift(input logic [127:0] s, input logic inv_sel);
        logic [7:0]   b [16];
        logic [127:0] res;
        int           sc;
        for (int k = 0; k < 16; k++) b[k] = s[127 - 8*k -: 8];
        res = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                sc = inv_sel ? ((c - r + 4) % 4) : ((c + r) % 4);
                res[127 - 8*(r + 4*c) -: 8] = b[r + 4*sc];
            end
        end
        return res;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: transfers are decided by values stable at the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_output", 128'd1, 128'd0);
                end else begin
                    chk("sb_data", state_out, exp_q.pop_front());
                end
            end
            if (in_valid && in_ready) exp_q.push_back(ref_shift(state_in, inv));
        end
    end

    typedef struct {
        logic [127:0] din;
        logic         inv;
        logic [127:0] exp;
    } vec_t;

    vec_t         tv [4];
    logic [127:0] blk_a, blk_b, blk_c, blk_d, x, y;

    initial begin
        tv[0] = '{128'hd42711ae_e0bf98f1_b8b45de5_1e415230, 1'b0, 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5};
        tv[1] = '{128'h49ded289_45db96f1_7f39871a_7702533b, 1'b0, 128'h49db873b_45395389_7f02d2f1_77de961a};
        tv[2] = '{128'hac73cf7b_efc111df_13b5d6b5_45235ab8, 1'b0, 128'hacc1d6b8_efb55a7b_1323cfdf_457311b5};
        tv[3] = '{128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5, 1'b1, 128'hd42711ae_e0bf98f1_b8b45de5_1e415230};

        in_valid = 1'b0; inv = 1'b0; state_in = '0; out_ready = 1'b1;

        // Asynchronous reset
        #1 rst_n = 1'b0;
        #1;
        chk("reset_out_valid", {127'd0, out_valid}, 128'd0);
        chk("reset_state_out", state_out, 128'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        chk("post_reset_in_ready", {127'd0, in_ready}, 128'd1);

        // Table vectors back-to-back, both builds
        for (int i = 0; i < 4; i++) begin
            state_in = tv[i].din; inv = tv[i].inv; in_valid = 1'b1;
            #1;
            chk($sformatf("comb_data[%0d]", i), c_state_out, tv[i].exp);
            chk($sformatf("comb_valid[%0d]", i), {127'd0, c_out_valid}, 128'd1);
            chk($sformatf("comb_ready[%0d]", i), {127'd0, c_in_ready}, {127'd0, out_ready});
            @(posedge clk); #1;
            chk($sformatf("pipe_valid[%0d]", i), {127'd0, out_valid}, 128'd1);
            chk($sformatf("pipe_data[%0d]", i), state_out, tv[i].exp);
        end
        in_valid = 1'b0;
        #1;
        chk("comb_valid_low", {127'd0, c_out_valid}, 128'd0);
        @(posedge clk); #1;
        chk("drain_valid_low", {127'd0, out_valid}, 128'd0);
        chk("drain_data_hold", state_out, tv[3].exp);

        // Backpressure with inv toggling while stalled
        blk_a = {$urandom, $urandom, $urandom, $urandom};
        blk_b = {$urandom, $urandom, $urandom, $urandom};
        out_ready = 1'b0; state_in = blk_a; inv = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        chk("bp_first_load", state_out, ref_shift(blk_a, 1'b0));
        state_in = blk_b;
        for (int i = 0; i < 3; i++) begin
            inv = ~inv;
            #1;
            chk($sformatf("bp_in_ready[%0d]", i), {127'd0, in_ready}, 128'd0);
            @(posedge clk); #1;
            chk($sformatf("bp_hold[%0d]", i), state_out, ref_shift(blk_a, 1'b0));
            chk($sformatf("bp_valid[%0d]", i), {127'd0, out_valid}, 128'd1);
        end
        inv = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_data", state_out, ref_shift(blk_b, 1'b1));
        chk("bp_release_valid", {127'd0, out_valid}, 128'd1);
        in_valid = 1'b0; state_in = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk); #1;
        chk("bp_empty_valid", {127'd0, out_valid}, 128'd0);
        state_in = {$urandom, $urandom, $urandom, $urandom}; inv = 1'b0;
        @(posedge clk); #1;
        chk("idle_garbage_ignored", state_out, ref_shift(blk_b, 1'b1));

        // Reset in the middle of a stall
        blk_c = {$urandom, $urandom, $urandom, $urandom};
        blk_d = {$urandom, $urandom, $urandom, $urandom};
        out_ready = 1'b0; state_in = blk_c; inv = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("midstall_reset_valid", {127'd0, out_valid}, 128'd0);
        chk("midstall_reset_data", state_out, 128'd0);
        exp_q.delete();
        @(posedge clk); #2;
        rst_n = 1'b1;
        chk("release_in_ready", {127'd0, in_ready}, 128'd1);
        state_in = blk_d; inv = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        chk("first_accept_valid", {127'd0, out_valid}, 128'd1);
        chk("first_accept_data", state_out, ref_shift(blk_d, 1'b0));

        // Random forward-then-inverse round trips
        for (int i = 0; i < 6; i++) begin
            x = {$urandom, $urandom, $urandom, $urandom};
            state_in = x; inv = 1'b0;
            @(posedge clk); #1;
            y = ref_shift(x, 1'b0);
            state_in = y; inv = 1'b1;
            @(posedge clk); #1;
            chk($sformatf("round_trip[%0d]", i), state_out, x);
        end
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("scoreboard_empty", 128'(exp_q.size()), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
